// File: rtl/uart_rx_fifo.sv
// Buffered 8N1 UART receiver: synchronised rx line, mid-bit sampling FSM and a show-ahead byte
// FIFO with sticky framing / overrun flags.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rx,
  input  logic                             rd_en,
  input  logic                             clear_err,
  output logic [7:0]                       rx_byte,
  output logic                             rx_byte_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
  output logic                             frame_err,
  output logic                             overrun
);

  localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CntW-1:0]   HalfBit  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0]   FullBit  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CountW-1:0] FullCnt  = CountW'(FIFO_DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge history
  // ---------------------------------------------------------------------------
  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0] sync_vld_q;

  // rx_prev is held low until the synchroniser has flushed its reset value, so a line that is
  // low through reset is never mistaken for a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b0;
      sync_vld_q <= 2'b00;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q & sync_vld_q[1];
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            expired, start_det, push_req, frame_evt;

  assign expired   = (cnt_q == '0);
  assign start_det = ~rx_sync_q & rx_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_evt = 1'b0;
    if (!expired) cnt_d = cnt_q - CntW'(1);
    case (state_q)
      StIdle: begin
        if (start_det) begin
          cnt_d   = HalfBit;
          state_d = StStart;
        end
      end
      StStart: begin
        if (expired) begin
          if (rx_sync_q) begin
            state_d = StIdle;
          end else begin
            cnt_d   = FullBit;
            idx_d   = 3'd0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (expired) begin
          shift_d[idx_q] = rx_sync_q;
          cnt_d          = FullBit;
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      StStop: begin
        if (expired) begin
          push_req  = rx_sync_q;
          frame_evt = ~rx_sync_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [7:0]        head_q, head_d;
  logic              do_pop, do_push, drop;
  logic              frame_err_q, frame_err_d, overrun_q, overrun_d;

  assign do_pop  = rd_en & (count_q != '0);
  assign do_push = push_req & ((count_q != FullCnt) | do_pop);
  assign drop    = push_req & ~do_push;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CountW'(1);
    else if (!do_push && do_pop) count_d = count_q - CountW'(1);
    // The new head may be the byte being written this very cycle.
    if (count_d == '0)                          head_d = 8'h00;
    else if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = shift_q;
    else                                        head_d = mem_q[rd_ptr_d];
    frame_err_d = (frame_err_q & ~clear_err) | frame_evt;
    overrun_d   = (overrun_q & ~clear_err) | drop;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_byte       = head_q;
  assign rx_byte_ready = (count_q != '0);
  assign count         = count_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;

endmodule
